// File: rtl/secret_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | secret_sched_pkg : shared types and constants for the job scheduler  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package secret_sched_pkg;

  localparam int          DATA_W      = 32;
  localparam logic [31:0] SECRET_INIT = 32'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at ptr          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [31:0]      idx;
  logic [IDX_W-1:0] sel;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    sel     = '0;
    for (int i = 0; i < N; i++) begin
      idx = (32'(ptr) + 32'(i)) % 32'(N);
      sel = idx[IDX_W-1:0];
      if (en && !found && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/secret_impl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | secret_impl : accumulator datapath shared by the scheduler           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module secret_impl
  import secret_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset_l,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] x
);

  logic [DATA_W-1:0] accum_q, accum_d;
  logic [DATA_W-1:0] secret_q, secret_d;
  logic [DATA_W-1:0] x_q, x_d;

  always_comb begin
    accum_d  = accum_q;
    secret_d = secret_q;
    x_d      = x_q;
    if (!reset_l) begin
      accum_d  = '0;
      secret_d = SECRET_INIT;
    end else begin
      accum_d = accum_q + a;
      x_d     = (accum_q > 32'd10) ? b : (a + b + secret_q);
    end
  end

  // x is deliberately left unreset; every job clears the datapath first.
  always_ff @(posedge clk) begin
    accum_q  <= accum_d;
    secret_q <= secret_d;
    x_q      <= x_d;
  end

  assign x = x_q;

endmodule
`default_nettype wire

// File: rtl/secret_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | secret_sched : round-robin job scheduler for one secret_impl         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module secret_sched
  import secret_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int BEAT_W = 4,
  parameter int ID_W   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ*BEAT_W-1:0]   req_beats,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     busy,
  output logic [DATA_W-1:0]        dp_a,
  output logic [DATA_W-1:0]        dp_b,
  output logic                     dp_reset_l,
  input  logic [DATA_W-1:0]        dp_x
);

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [BEAT_W-1:0] sel_beats;

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (state_q == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_beats = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a     = req_a[i*DATA_W +: DATA_W];
        sel_b     = req_b[i*DATA_W +: DATA_W];
        sel_beats = req_beats[i*BEAT_W +: BEAT_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          a_d     = sel_a;
          b_d     = sel_b;
          cnt_d   = (sel_beats == '0) ? BEAT_W'(1) : sel_beats;
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == BEAT_W'(1)) state_d = CAPT;
        else                     cnt_d   = cnt_q - 1'b1;
      end
      CAPT: begin
        data_d  = dp_x;
        state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  // Holding the datapath in reset outside RUN/CAPT guarantees a clean start per job.
  assign req_ready  = gnt;
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign dp_reset_l = (state_q == RUN) || (state_q == CAPT);
  assign dp_a       = (state_q == RUN) ? a_q : '0;
  assign dp_b       = (state_q == RUN) ? b_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_secret_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_secret_sched : self-checking bench, job-level model + directed     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_secret_sched;
  import secret_sched_pkg::*;

  localparam int NREQ   = 4;
  localparam int BEAT_W = 4;
  localparam int ID_W   = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*32-1:0]     req_a = '0;
  logic [NREQ*32-1:0]     req_b = '0;
  logic [NREQ*BEAT_W-1:0] req_beats = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [ID_W-1:0]        rsp_id;
  logic [31:0]            rsp_data;
  logic                   busy;
  logic [31:0]            dp_a, dp_b, dp_x;
  logic                   dp_reset_l;

  secret_sched #(.NREQ(NREQ), .BEAT_W(BEAT_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_beats(req_beats),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .dp_a(dp_a), .dp_b(dp_b), .dp_reset_l(dp_reset_l), .dp_x(dp_x)
  );

  secret_impl u_dp (.clk(clk), .reset_l(dp_reset_l), .a(dp_a), .b(dp_b), .x(dp_x));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b, input int n);
    logic [31:0] acc;
    acc = a * 32'(n - 1);
    return (acc > 32'd10) ? b : (a + b + SECRET_INIT);
  endfunction

  // Job-level reference: a job accepted at cycle c with n beats occupies
  // c+1..c+n (operands on the bus), c+n+1 (capture), then presents from c+n+2.
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_acc = 0, m_n = 0, m_ptr = 0, m_id = 0;
  logic [31:0] m_a = '0, m_b = '0;
  bit          chk_rst = 1'b0;
  int          g, k, p;
  logic [BEAT_W-1:0] m_beats;
  logic [NREQ-1:0]   e_ready;
  logic              e_busy, e_dprl, e_valid;
  logic [31:0]       e_a, e_b;

  always @(negedge clk) begin : model
    cyc++;
    if (reset) begin
      m_active = 1'b0;
      m_ptr    = 0;
      m_id     = 0;
      chk_rst  = 1'b1;
    end else begin
      if (chk_rst) begin
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk_rst = 1'b0;
      end
      g = -1;
      e_ready = '0;
      if (!m_active) begin
        for (int i = 0; i < NREQ; i++) begin
          p = (m_ptr + i) % NREQ;
          if (g < 0 && req_valid[p[1:0]]) g = p;
        end
        if (g >= 0) e_ready[g[1:0]] = 1'b1;
        e_busy = 1'b0; e_dprl = 1'b0; e_a = '0; e_b = '0; e_valid = 1'b0;
      end else begin
        k       = cyc - m_acc;
        e_busy  = 1'b1;
        e_dprl  = (k <= m_n + 1);
        e_a     = (k <= m_n) ? m_a : 32'd0;
        e_b     = (k <= m_n) ? m_b : 32'd0;
        e_valid = (k >= m_n + 2);
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("dp_reset_l", 32'(dp_reset_l), 32'(e_dprl));
      chk("dp_a", dp_a, e_a);
      chk("dp_b", dp_b, e_b);
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      if (e_valid) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_data", rsp_data, exp_result(m_a, m_b, m_n));
      end
      if (!m_active && g >= 0) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_a      = req_a[g*32 +: 32];
        m_b      = req_b[g*32 +: 32];
        m_beats  = req_beats[g*BEAT_W +: BEAT_W];
        m_n      = (m_beats == '0) ? 1 : int'(m_beats);
        m_id     = g;
        m_ptr    = (g + 1) % NREQ;
      end else if (m_active && e_valid && rsp_ready) begin
        m_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [BEAT_W-1:0] beats);
    req_a[i*32 +: 32]             = a;
    req_b[i*32 +: 32]             = b;
    req_beats[i*BEAT_W +: BEAT_W] = beats;
  endtask

  task automatic wait_accept(input int id, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 200 && !idle; t++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) chk("idle_timeout", 32'd0, 32'd1);
    tick();
  endtask

  // Single-requester job with literal expected result and accept-to-valid latency.
  task automatic run_job(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [BEAT_W-1:0] beats, input logic [31:0] exp_data,
                         input int exp_lat, input string nm);
    bit ok;
    int lat;
    set_port(id, a, b, beats);
    req_valid = '0;
    req_valid[id] = 1'b1;
    rsp_ready = 1'b1;
    wait_accept(id, ok);
    tick();
    req_valid = '0;
    lat = 0;
    ok  = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) ok = 1'b1;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_data"}, rsp_data, exp_data);
    chk({nm, "_id"}, 32'(rsp_id), 32'(id));
    tick();
  endtask

  int          acc_id[5];
  time         acc_t[5];
  int          n_acc;
  logic [31:0] held;
  int          seen;
  bit          ok;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Fairness: all ports requesting, 2-beat jobs, spacing must be 2+3 cycles.
    for (int i = 0; i < NREQ; i++) set_port(i, 32'(i + 1), 32'(i + 100), 4'd2);
    req_valid = '1;
    n_acc = 0;
    for (int t = 0; t < 200 && n_acc < 5; t++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          acc_id[n_acc] = i;
          acc_t[n_acc]  = $time;
        end
      end
      if (|req_ready) n_acc++;
    end
    tick();
    req_valid = '0;
    chk("fair_count", 32'(n_acc), 32'd5);
    for (int i = 0; i < 5; i++) chk("fair_order", 32'(acc_id[i]), 32'(i % NREQ));
    for (int i = 1; i < 5; i++) chk("fair_spacing", 32'((acc_t[i] - acc_t[i-1]) / 10), 32'd5);
    wait_idle();

    run_job(0, 32'd1, 32'd2, 4'd1, 32'd12, 3, "single");
    run_job(2, 32'd5, 32'd7, 4'd3, 32'd21, 5, "thresh_eq");
    run_job(2, 32'd6, 32'd7, 4'd3, 32'd7, 5, "thresh_gt");
    run_job(1, 32'd3, 32'd4, 4'd0, 32'd16, 3, "zero_beats");
    run_job(3, 32'd0, 32'd5, 4'd15, 32'd14, 17, "max_beats");

    // Backpressure: hold rsp_ready low for 10 cycles of rsp_valid.
    set_port(3, 32'd2, 32'd3, 4'd2);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    wait_accept(3, ok);
    tick();
    req_valid = '1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    held = rsp_data;
    chk("bp_data", held, 32'd14);
    for (int t = 0; t < 10; t++) begin
      if (t > 0) @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_stable", rsp_data, held);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_no_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_resume_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    wait_idle();

    // Reset mid-RUN: 8-beat job, reset during cycle 4.
    set_port(0, 32'd1, 32'd1, 4'd8);
    req_valid = 4'b0001;
    wait_accept(0, ok);
    tick();
    req_valid = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_dprl", 32'(dp_reset_l), 32'd0);
    chk("mid_rst_dpa", dp_a, 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    seen = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mid_rst_no_rsp", 32'(seen), 32'd0);
    tick();
    run_job(0, 32'd1, 32'd2, 4'd1, 32'd12, 3, "post_rst");

    // Randomized traffic checked by the job-level model.
    for (int t = 0; t < 3000; t++) begin
      tick();
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_port(i, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : $urandom,
                   $urandom, BEAT_W'($urandom));
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 299) == 0);
    end
    tick();
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/secret_sched.md
# secret_sched

Round-robin scheduler that shares one `secret_impl` accumulator datapath between `NREQ` requesters. It accepts one job at a time: operands `a`, `b` and a beat count. For each job it clears the datapath, drives the operands for the requested number of beats, captures the datapath result and returns it tagged with the requester id. It sits between the client ports and the single protected-library instance, which it connects to directly.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `BEAT_W`, 4: width of each beat-count field.
- `ID_W`, `$clog2(NREQ)`: width of the response id.
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NREQ: per-requester job request.
- `req_ready`  out  NREQ: one-hot grant/accept; zero outside IDLE.
- `req_a`  in  NREQ*32: flattened operand a; requester i uses bits [32i+31:32i].
- `req_b`  in  NREQ*32: flattened operand b.
- `req_beats`  in  NREQ*BEAT_W: beats per job; value 0 is treated as 1.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: result consumed.
- `rsp_id`  out  ID_W: index of the requester that owns the result.
- `rsp_data`  out  32: captured datapath `x`.
- `busy`  out  1: high in any state except IDLE.
- `dp_a`, `dp_b`  out  32 each: datapath operands.
- `dp_reset_l`  out  1: datapath active-low reset.
- `dp_x`  in  32: datapath result.

## Operation
- Datapath model, per clock:
  - `reset_l`=0: accum←0, secret←9.
  - Otherwise: accum←accum+a, and x←(accum>10) ? b : a+b+secret.
  - All arithmetic is mod 2^32 and unsigned.
- FSM states: IDLE, RUN, CAPT, DONE.
- IDLE:
  - Round-robin arbiter picks the first requester with `req_valid` high, searching from pointer `ptr`.
  - `req_ready[g]` is asserted combinationally in the same cycle; the handshake completes that cycle.
  - On accept: latch a, b, beats (0→1) and id; set `ptr`←(g+1) mod NREQ; go to RUN.
  - With no valid requester, stay in IDLE and leave `ptr` unchanged.
- RUN:
  - Drive `dp_a`=a, `dp_b`=b, `dp_reset_l`=1.
  - A down-counter counts the latched beats; after the last beat go to CAPT.
- CAPT:
  - `dp_reset_l`=1, `dp_a`=`dp_b`=0.
  - Register `dp_x` into `rsp_data`; go to DONE.
- DONE:
  - Assert `rsp_valid`; hold `rsp_id` and `rsp_data` stable.
  - When `rsp_valid`&&`rsp_ready`, go to IDLE.
- `dp_reset_l`=0 in IDLE, DONE and reset, so the datapath is always cleared at job start.
- `dp_a`=`dp_b`=0 in every state except RUN.
- New requests are never accepted while busy; `req_valid` may stay high across that time.

## Timing
- Reset values:
  - state IDLE, `ptr`=0.
  - `req_ready`=0 and `rsp_valid`=0.
  - `rsp_id`=0, `rsp_data`=0.
  - `busy`=0, `dp_reset_l`=0, `dp_a`=`dp_b`=0.
- For a job of n beats accepted in cycle 0:
  - RUN occupies cycles 1..n.
  - CAPT is cycle n+1.
  - `rsp_valid` rises in cycle n+2.
- Minimum accept-to-accept spacing is n+3 cycles when `rsp_ready` is tied high. The DONE→IDLE handshake cycle cannot also accept.
- Expected result = ((n-1)·a > 10) ? b : a+b+9, where (n-1)·a is the mod-2^32 accumulated value.
- Boundary and corner cases:
  - Requests on all ports simultaneously: grant order follows `ptr`.
  - Pointer wrap: NREQ-1 wraps to 0.
  - `reset` asserted mid-job (any state): next cycle is IDLE with reset values; the in-flight result is discarded and never presented.
  - `rsp_ready` held low: stay in DONE indefinitely with all outputs stable.
  - Maximum beats: 2^BEAT_W−1.

## Structure
- Package `secret_sched_pkg`:
  - state enum `sched_state_e` {IDLE, RUN, CAPT, DONE}.
  - `DATA_W`=32.
  - `SECRET_INIT`=9 (for bench models).
- Sub-module `rr_arbiter`, parameterised on N:
  - Inputs: `req` vector, `ptr`, `en`.
  - Outputs: one-hot `gnt` and binary `gnt_idx`.
  - Purely combinational; the pointer register stays in `secret_sched`.
- The bench instantiates `secret_sched` driving a real `secret_impl`, with `reset_l` tied to `dp_reset_l`.

## Test plan
- Single job, requester 0: a=1, b=2, beats=1 → `rsp_valid` in cycle 3, `rsp_data`=12, `rsp_id`=0.
- Threshold check, requester 2:
  - a=5, b=7, beats=3 → `rsp_data`=21 (accum 10 is not >10).
  - a=6, b=7, beats=3 → `rsp_data`=7.
- Fairness: all 4 requesters hold `req_valid` with `rsp_ready`=1 → grant order 0,1,2,3,0; each accept exactly n+3 cycles apart.
- Backpressure: `rsp_ready`=0 for 10 cycles after `rsp_valid` → outputs stable, `req_ready`=0 throughout; accept resumes in the cycle after the handshake.
- Reset mid-RUN: beats=8, `reset` asserted at cycle 4 → no response; all outputs at reset values next cycle; a following job behaves as from power-up.
- beats=0 with a=3, b=4 → treated as 1 beat, `rsp_data`=16, `rsp_valid` in cycle 3.
